remote_comm: RTL and testbench

//  Host-side command sender: serialises a 16-bit command as two UART bytes (high then low)
//  and captures the single-byte response. It drives the RX line of the command receiver that

---
 rtl/remote_comm.sv | 272 +++++++++++++++++++++++++++
 tb/tb_remote_comm.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// remote_comm: host-side command sender -- a 16-bit command goes out as two UART bytes
// (high, then low) and the single-byte response is captured. Optional macro RESP_TMO_EN.

module UART #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2);

    logic [8:0]  tx_shft_q;
    logic [3:0]  tx_bits_q;
    logic [15:0] tx_baud_q;
    logic        tx_busy_q;
    logic        tx_done_q;

    logic        rx_ff1_q, rx_ff2_q;
    logic        rx_busy_q;
    logic [3:0]  rx_bits_q;
    logic [15:0] rx_baud_q;
    logic [7:0]  rx_shft_q;
    logic [7:0]  rx_data_q;
    logic        rx_rdy_q;

    // Frame shifts out LSB first: start bit, 8 data bits, then 1s fill in as the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft_q <= 9'h1FF;
            tx_bits_q <= 4'd0;
            tx_baud_q <= 16'd0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else if (trmt) begin
            tx_shft_q <= {tx_data, 1'b0};
            tx_bits_q <= 4'd0;
            tx_baud_q <= 16'd0;
            tx_busy_q <= 1'b1;
            tx_done_q <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q == BAUD_LAST) begin
                tx_baud_q <= 16'd0;
                tx_shft_q <= {1'b1, tx_shft_q[8:1]};
                tx_bits_q <= tx_bits_q + 4'd1;
                if (tx_bits_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1_q <= 1'b1;
            rx_ff2_q <= 1'b1;
        end else begin
            rx_ff1_q <= RX;
            rx_ff2_q <= rx_ff1_q;
        end
    end

    // Sampling starts half a bit after the falling edge, so every sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy_q <= 1'b0;
            rx_bits_q <= 4'd0;
            rx_baud_q <= 16'd0;
            rx_shft_q <= 8'h00;
            rx_data_q <= 8'h00;
            rx_rdy_q  <= 1'b0;
        end else begin
            if (clr_rx_rdy) rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_ff2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= BAUD_HALF;
                    rx_bits_q <= 4'd0;
                end
            end else if (rx_baud_q == BAUD_LAST) begin
                rx_baud_q <= 16'd0;
                rx_bits_q <= rx_bits_q + 4'd1;
                if (rx_bits_q == 4'd0) begin
                    if (rx_ff2_q) rx_busy_q <= 1'b0;
                end else if (rx_bits_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_data_q <= rx_shft_q;
                    rx_rdy_q  <= 1'b1;
                end else begin
                    rx_shft_q <= {rx_ff2_q, rx_shft_q[7:1]};
                end
            end else begin
                rx_baud_q <= rx_baud_q + 16'd1;
            end
        end
    end

    assign TX      = tx_shft_q[0];
    assign tx_done = tx_done_q;
    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;
endmodule

module remote_comm #(
    parameter int TMO_CYCLES = 1_000_000,
    parameter int BAUD_DIV   = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        busy,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy
`ifdef RESP_TMO_EN
    ,
    output logic        resp_tmo
`endif
);
    if (TMO_CYCLES < 2) begin : g_bad_tmo
        $error("remote_comm: TMO_CYCLES must be at least 2");
    end

`ifdef RESP_TMO_EN
    typedef enum logic [1:0] {IDLE, HIGH, LOW, WAIT_RESP} state_t;
    localparam int              TMO_W    = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_CYCLES);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             resp_tmo_q, resp_tmo_d;
`else
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] low_buf_q, low_buf_d;
    logic       cmd_snt_q, cmd_snt_d;
    logic [7:0] resp_q, resp_d;
    logic       resp_rdy_q, resp_rdy_d;
    logic       trmt, tx_done, rx_rdy, clr_rx_rdy;
    logic [7:0] tx_data, rx_data;

    UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy)
    );

    // In IDLE the high byte comes straight from the live cmd so trmt can fire on accept.
    assign tx_data = (state_q == IDLE) ? cmd[15:8] : low_buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            low_buf_q  <= 8'h00;
            cmd_snt_q  <= 1'b0;
            resp_q     <= 8'h00;
            resp_rdy_q <= 1'b0;
`ifdef RESP_TMO_EN
            tmo_cnt_q  <= '0;
            resp_tmo_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            low_buf_q  <= low_buf_d;
            cmd_snt_q  <= cmd_snt_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
`ifdef RESP_TMO_EN
            tmo_cnt_q  <= tmo_cnt_d;
            resp_tmo_q <= resp_tmo_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        low_buf_d  = low_buf_q;
        cmd_snt_d  = cmd_snt_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        trmt       = 1'b0;
        clr_rx_rdy = 1'b0;
`ifdef RESP_TMO_EN
        tmo_cnt_d  = tmo_cnt_q;
        resp_tmo_d = resp_tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (snd_cmd) begin
                    trmt       = 1'b1;
                    low_buf_d  = cmd[7:0];
                    cmd_snt_d  = 1'b0;
                    resp_rdy_d = 1'b0;
`ifdef RESP_TMO_EN
                    resp_tmo_d = 1'b0;
`endif
                    state_d    = HIGH;
                end
            end
            HIGH: begin
                if (tx_done) begin
                    trmt    = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tx_done) begin
                    cmd_snt_d = 1'b1;
`ifdef RESP_TMO_EN
                    tmo_cnt_d = '0;
                    state_d   = WAIT_RESP;
`else
                    state_d   = IDLE;
`endif
                end
            end
`ifdef RESP_TMO_EN
            WAIT_RESP: begin
                if (rx_rdy) begin
                    state_d = IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    resp_tmo_d = 1'b1;
                    state_d    = IDLE;
                end else if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Response capture runs in every state; a new byte beats a same-cycle clear.
        if (rx_rdy) begin
            resp_d     = rx_data;
            resp_rdy_d = 1'b1;
            clr_rx_rdy = 1'b1;
        end else if (clr_resp_rdy) begin
            resp_rdy_d = 1'b0;
        end
    end

    assign busy     = (state_q != IDLE);
    assign cmd_snt  = cmd_snt_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;
`ifdef RESP_TMO_EN
    assign resp_tmo = resp_tmo_q;
`endif
endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm: decodes TX independently, drives RX frames,
// and covers reset, command table, ignored snd_cmd, response capture and mid-transfer reset.

module tb_remote_comm;
    localparam int BAUD = 8;
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd = 16'h0000;
    logic        snd_cmd = 1'b0;
    logic        cmd_snt, busy, resp_rdy;
    logic [7:0]  resp;
    logic        clr_resp_rdy = 1'b0;
`ifdef RESP_TMO_EN
    logic        resp_tmo;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_q[$];

    remote_comm #(.TMO_CYCLES(TMO), .BAUD_DIV(BAUD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX           (RX),
        .TX           (TX),
        .cmd          (cmd),
        .snd_cmd      (snd_cmd),
        .cmd_snt      (cmd_snt),
        .busy         (busy),
        .resp         (resp),
        .resp_rdy     (resp_rdy),
        .clr_resp_rdy (clr_resp_rdy)
`ifdef RESP_TMO_EN
        ,
        .resp_tmo     (resp_tmo)
`endif
    );

    always #5 clk = ~clk;

    // Independent serial decoder on TX.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge TX);
            repeat (BAUD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                b[i] = TX;
            end
            repeat (BAUD) @(negedge clk);
            tx_q.push_back(b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic wait_cmd_snt(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (cmd_snt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_snt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < TMO + 200; n++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge where the DUT is idle again.
    task automatic do_cmd(input logic [15:0] c, input logic [7:0] hi, input logic [7:0] lo,
                          input bit glitch);
        bit ok;
        tx_q.delete();
        cmd = c;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        check("cmd_snt_cleared", cmd_snt, 1'b0);
`ifdef RESP_TMO_EN
        check("resp_tmo_cleared", resp_tmo, 1'b0);
`endif
        if (glitch) begin
            repeat (10) @(negedge clk);
            cmd = 16'h1234;
            snd_cmd = 1'b1;
            @(negedge clk);
            snd_cmd = 1'b0;
        end
        wait_cmd_snt(ok);
        if (ok) begin
            check("tx_byte_count", tx_q.size(), 2);
            if (tx_q.size() == 2) begin
                check("tx_high_byte", tx_q[0], hi);
                check("tx_low_byte", tx_q[1], lo);
            end
`ifdef RESP_TMO_EN
            check("busy_in_wait_resp", busy, 1'b1);
`else
            check("busy_after_cmd_snt", busy, 1'b0);
`endif
        end
        wait_idle();
    endtask

    typedef struct {
        logic [15:0] c;
        logic [7:0]  hi;
        logic [7:0]  lo;
        bit          glitch;
    } cmd_vec_t;

    typedef struct {
        logic [7:0] b;
        bit         clr;
    } rsp_vec_t;

    cmd_vec_t cvec[5];
    rsp_vec_t rvec[3];

    initial begin
        cvec[0] = '{16'hA55A, 8'hA5, 8'h5A, 1'b0};
        cvec[1] = '{16'hA55A, 8'hA5, 8'h5A, 1'b1};
        cvec[2] = '{16'h0000, 8'h00, 8'h00, 1'b0};
        cvec[3] = '{16'hFFFF, 8'hFF, 8'hFF, 1'b0};
        cvec[4] = '{16'h8001, 8'h80, 8'h01, 1'b0};
        rvec[0] = '{8'hA5, 1'b1};
        rvec[1] = '{8'h0F, 1'b0};
        rvec[2] = '{8'h3C, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_TX", TX, 1'b1);
        check("rst_cmd_snt", cmd_snt, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_rdy", resp_rdy, 1'b0);
        check("rst_resp", resp, 8'h00);
`ifdef RESP_TMO_EN
        check("rst_resp_tmo", resp_tmo, 1'b0);
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Command table, issued back-to-back
        foreach (cvec[i]) do_cmd(cvec[i].c, cvec[i].hi, cvec[i].lo, cvec[i].glitch);

        // Response table: capture, clear, overwrite
        repeat (5) @(negedge clk);
        foreach (rvec[i]) begin
            send_rx(rvec[i].b);
            check("resp_value", resp, rvec[i].b);
            check("resp_rdy_set", resp_rdy, 1'b1);
            if (rvec[i].clr) begin
                clr_resp_rdy = 1'b1;
                @(negedge clk);
                clr_resp_rdy = 1'b0;
                check("resp_rdy_cleared", resp_rdy, 1'b0);
                check("resp_kept", resp, rvec[i].b);
            end
        end

        // Clear in the same cycle as a new byte: set wins
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
        check("resp_rdy_pre_clear", resp_rdy, 1'b0);
        fork
            send_rx(8'h66);
            begin
                bit seen = 1'b0;
                for (int n = 0; n < 200; n++) begin
                    @(negedge clk);
                    if (dut.rx_rdy) begin
                        seen = 1'b1;
                        clr_resp_rdy = 1'b1;
                        @(negedge clk);
                        clr_resp_rdy = 1'b0;
                        check("set_wins_rdy", resp_rdy, 1'b1);
                        check("set_wins_resp", resp, 8'h66);
                        break;
                    end
                end
                if (!seen) check("rx_rdy_timeout", 32'd0, 32'd1);
            end
        join

`ifdef RESP_TMO_EN
        // Timeout: resp_tmo exactly TMO cycles after cmd_snt
        begin
            bit ok;
            int n;
            cmd = 16'h0102;
            snd_cmd = 1'b1;
            @(negedge clk);
            snd_cmd = 1'b0;
            wait_cmd_snt(ok);
            n = 0;
            while (ok && !resp_tmo && n < TMO + 50) begin
                @(negedge clk);
                n++;
            end
            check("tmo_latency", n, TMO);
            check("tmo_flag", resp_tmo, 1'b1);
            check("tmo_busy", busy, 1'b0);

            cmd = 16'h0304;
            snd_cmd = 1'b1;
            @(negedge clk);
            snd_cmd = 1'b0;
            check("tmo_clear_on_accept", resp_tmo, 1'b0);
            wait_cmd_snt(ok);
            repeat (500) @(negedge clk);
            send_rx(8'hA5);
            check("resp_in_wait", resp, 8'hA5);
            check("no_tmo_with_resp", resp_tmo, 1'b0);
            check("idle_after_resp", busy, 1'b0);
        end
`endif

        // Reset in the middle of the low byte
        cmd = 16'hF00F;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (10 * BAUD + 4 * BAUD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_TX", TX, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_cmd_snt", cmd_snt, 1'b0);
        check("midrst_resp_rdy", resp_rdy, 1'b0);
        check("midrst_resp", resp, 8'h00);
        begin
            int lows = 0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (TX !== 1'b1) lows++;
            end
            rst_n = 1'b1;
            for (int n = 0; n < 12 * BAUD; n++) begin
                @(negedge clk);
                if (TX !== 1'b1) lows++;
            end
            check("no_byte_after_reset", lows, 0);
        end
        do_cmd(16'hC3C3, 8'hC3, 8'hC3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
